column_l1_deroute: RTL and testbench



---
 rtl/column_l1_deroute_pkg.sv | 13 +
 rtl/inv_cyclic_shifter.sv | 21 ++
 rtl/column_l1_deroute.sv | 128 ++++++++++++
 tb/tb_column_l1_deroute.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_l1_deroute_pkg.sv
// Shared constants for the column L1 return route: destination codes and FSM encoding.
package column_l1_deroute_pkg;

  localparam logic DST_VNU = 1'b0;
  localparam logic DST_DEC = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/inv_cyclic_shifter.sv
// Combinational inverse cyclic rotate of one stride unit: out lane k = in lane (k - shift) mod Z.
module inv_cyclic_shifter #(
  parameter int unsigned Z           = 15,
  parameter int unsigned QUAN_SIZE   = 4,
  parameter int unsigned SHIFT_WIDTH = $clog2(Z)
) (
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [Z*QUAN_SIZE-1:0] unit_in,
  output logic [Z*QUAN_SIZE-1:0] unit_out
);

  always_comb begin
    unit_out = '0;
    for (int unsigned k = 0; k < Z; k++) begin
      // 2*Z bias keeps the subtraction non-negative for any shift below 2^SHIFT_WIDTH
      unit_out[k*QUAN_SIZE +: QUAN_SIZE] =
          unit_in[((k + 2 * Z - 32'(shift)) % Z) * QUAN_SIZE +: QUAN_SIZE];
    end
  end

endmodule

// File: rtl/column_l1_deroute.sv
// Column L1 return route: undoes the per-unit cyclic shift of each beat and steers the
// registered result to the VNU or the decision path, one burst at a time.
module column_l1_deroute
  import column_l1_deroute_pkg::*;
#(
  parameter int unsigned QUAN_SIZE        = 4,
  parameter int unsigned STRIDE_UNIT_SIZE = 15,
  parameter int unsigned STRIDE_WIDTH     = 3,
  parameter int unsigned SHIFT_WIDTH      = $clog2(STRIDE_UNIT_SIZE),
  parameter int unsigned BEAT_CNT_WIDTH   = 8,
  parameter int unsigned MSG_W            = STRIDE_WIDTH * STRIDE_UNIT_SIZE * QUAN_SIZE
) (
  input  logic                      sys_clk,
  input  logic                      rstn,
  input  logic                      start_i,
  input  logic [SHIFT_WIDTH-1:0]    shift_factor_i,
  input  logic                      dst_sel_i,
  input  logic [BEAT_CNT_WIDTH-1:0] burst_len_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [MSG_W-1:0]          in_msg_i,
  output logic                      vnu_valid_o,
  input  logic                      vnu_ready_i,
  output logic [MSG_W-1:0]          vnu_msg_o,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [MSG_W-1:0]          dec_msg_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned UnitW = STRIDE_UNIT_SIZE * QUAN_SIZE;

  state_e                    state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] cnt_q;
  logic [SHIFT_WIDTH-1:0]    shift_q, shift_mod;
  logic                      dst_q;
  logic                      out_valid_q;
  logic [MSG_W-1:0]          out_msg_q;
  logic                      done_q, done_d;
  logic [MSG_W-1:0]          rot_msg;
  logic                      sel_ready, pop, push, latch;

  assign shift_mod = SHIFT_WIDTH'(32'(shift_factor_i) % STRIDE_UNIT_SIZE);
  assign sel_ready = (dst_q == DST_DEC) ? dec_ready_i : vnu_ready_i;
  assign pop       = out_valid_q && sel_ready;
  assign push      = in_valid_i && in_ready_o;
  assign latch     = (state_q == StIdle) && start_i;

  for (genvar u = 0; u < STRIDE_WIDTH; u++) begin : g_unit
    inv_cyclic_shifter #(
      .Z           (STRIDE_UNIT_SIZE),
      .QUAN_SIZE   (QUAN_SIZE),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_shift (
      .shift    (shift_q),
      .unit_in  (in_msg_i[u*UnitW +: UnitW]),
      .unit_out (rot_msg[u*UnitW +: UnitW])
    );
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (burst_len_i != '0) ? StRun : StDrain;
      end
      StRun: begin
        if (push && cnt_q == BEAT_CNT_WIDTH'(1)) state_d = StDrain;
      end
      StDrain: begin
        if (!out_valid_q || pop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != StIdle);
    in_ready_o = (state_q == StRun) && (!out_valid_q || sel_ready);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      dst_q       <= DST_VNU;
      out_valid_q <= 1'b0;
      out_msg_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      if (latch) begin
        cnt_q   <= burst_len_i;
        shift_q <= shift_mod;
        dst_q   <= dst_sel_i;
      end else if (push) begin
        cnt_q <= cnt_q - BEAT_CNT_WIDTH'(1);
      end
      if (push) begin
        out_valid_q <= 1'b1;
        out_msg_q   <= rot_msg;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // The unselected consumer sees a silent, all-zero bus.
  assign vnu_valid_o = out_valid_q && (dst_q == DST_VNU);
  assign dec_valid_o = out_valid_q && (dst_q == DST_DEC);
  assign vnu_msg_o   = (dst_q == DST_VNU) ? out_msg_q : '0;
  assign dec_msg_o   = (dst_q == DST_DEC) ? out_msg_q : '0;
  assign done_o      = done_q;

endmodule

// File: tb/tb_column_l1_deroute.sv
// Scoreboard bench for column_l1_deroute: stimulus pushes expected beats, a monitor pops on handshakes.
module tb_column_l1_deroute;

  localparam int Q     = 4;
  localparam int Z     = 15;
  localparam int U     = 3;
  localparam int SW    = 4;
  localparam int BW    = 8;
  localparam int MSG_W = U * Z * Q;

  typedef struct packed {
    logic             dst;
    logic [MSG_W-1:0] msg;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [SW-1:0]    shift;
  logic             dst_sel;
  logic [BW-1:0]    blen;
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_msg;
  logic             vnu_valid, dec_valid;
  logic             vnu_ready;
  logic             dec_ready = 1'b1;
  logic [MSG_W-1:0] vnu_msg, dec_msg;
  logic             busy, done;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vnu_hs = 0;
  int   dec_hs = 0;
  bit   bp_en = 1'b0;

  column_l1_deroute dut (
    .sys_clk        (clk),
    .rstn           (rstn),
    .start_i        (start),
    .shift_factor_i (shift),
    .dst_sel_i      (dst_sel),
    .burst_len_i    (blen),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_msg_i       (in_msg),
    .vnu_valid_o    (vnu_valid),
    .vnu_ready_i    (vnu_ready),
    .vnu_msg_o      (vnu_msg),
    .dec_valid_o    (dec_valid),
    .dec_ready_i    (dec_ready),
    .dec_msg_o      (dec_msg),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    dec_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic d, input logic [MSG_W-1:0] m);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_beat: got dst %0d with empty scoreboard, required none", d);
    end else begin
      e = sb.pop_front();
      chk_int("beat_dst", 32'(d), 32'(e.dst));
      chk("beat_msg", m, e.msg);
    end
  endtask

  // Monitor: compare every delivered beat against the scoreboard head.
  always @(negedge clk) begin
    if (rstn) begin
      if (vnu_valid && dec_valid) chk_int("both_valid", 32'(dec_valid), 32'(0));
      if (vnu_valid && vnu_ready) begin
        vnu_hs++;
        pop_cmp(1'b0, vnu_msg);
      end
      if (dec_valid && dec_ready) begin
        dec_hs++;
        pop_cmp(1'b1, dec_msg);
      end
      if ((vnu_valid && !vnu_ready) || (dec_valid && !dec_ready))
        chk_int("in_ready_stall", 32'(in_ready), 32'(0));
    end
  end

  function automatic logic [MSG_W-1:0] fwd(input logic [MSG_W-1:0] d, input int s);
    logic [MSG_W-1:0] r;
    r = '0;
    for (int u = 0; u < U; u++)
      for (int j = 0; j < Z; j++)
        r[(u*Z+j)*Q +: Q] = d[(u*Z+(j+s)%Z)*Q +: Q];
    return r;
  endfunction

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] r;
    r = '0;
    for (int l = 0; l < U * Z; l++) r[l*Q +: Q] = 4'($urandom);
    return r;
  endfunction

  task automatic start_burst(input int s, input logic d, input int len);
    start   = 1'b1;
    shift   = SW'(s);
    dst_sel = d;
    blen    = BW'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [MSG_W-1:0] m, input logic d, input logic [MSG_W-1:0] e);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_msg   = m;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (!acc) chk_int("send_accept", 32'(acc), 32'(1));
    else sb.push_back('{dst: d, msg: e});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk_int("done_seen", 32'(seen), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk_int("rst_vnu_valid", 32'(vnu_valid), 32'(0));
    chk_int("rst_dec_valid", 32'(dec_valid), 32'(0));
    chk_int("rst_in_ready", 32'(in_ready), 32'(0));
    chk_int("rst_busy", 32'(busy), 32'(0));
    chk_int("rst_done", 32'(done), 32'(0));
    chk("rst_vnu_msg", vnu_msg, '0);
    chk("rst_dec_msg", dec_msg, '0);
  endtask

  initial begin
    logic [MSG_W-1:0] d, e;
    int h0, h1;
    int shifts[3] = '{0, 7, 14};
    rstn = 1'b0; start = 1'b0; shift = '0; dst_sel = 1'b0; blen = '0;
    in_valid = 1'b0; in_msg = '0; vnu_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // in_valid while idle must be ignored
    in_valid = 1'b1;
    in_msg   = rand_msg();
    repeat (3) begin
      @(negedge clk);
      chk_int("idle_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Rotation check: lane l holds l, s=3
    h0 = dec_hs;
    start_burst(3, 1'b0, 1);
    for (int l = 0; l < U * Z; l++) begin
      d[l*Q +: Q] = 4'(l % Z);
      e[l*Q +: Q] = 4'(((l % Z) + 12) % Z);
    end
    send(d, 1'b0, e);
    @(negedge clk);
    chk_int("rot_lane0", 32'(vnu_msg[0 +: Q]), 32'd12);
    chk_int("rot_lane3", 32'(vnu_msg[3*Q +: Q]), 32'd0);
    chk_int("rot_lane14", 32'(vnu_msg[14*Q +: Q]), 32'd11);
    chk_int("rot_u2_lane0", 32'(vnu_msg[30*Q +: Q]), 32'd12);
    chk_int("rot_done_early", 32'(done), 32'(0));
    @(negedge clk);
    chk_int("rot_done_n2", 32'(done), 32'(1));
    @(negedge clk);
    chk_int("rot_done_pulse", 32'(done), 32'(0));
    chk_int("rot_no_dec", 32'(dec_hs - h0), 32'(0));
    @(posedge clk);
    #1;

    // Round trip through the forward route
    for (int k = 0; k < 3; k++) begin
      h0 = vnu_hs;
      start_burst(shifts[k], 1'b0, 20);
      for (int b = 0; b < 20; b++) begin
        d = rand_msg();
        send(fwd(d, shifts[k]), 1'b0, d);
      end
      wait_done();
      chk_int("rt_hs_count", 32'(vnu_hs - h0), 32'd20);
    end

    // Backpressure on the decision path
    h0 = dec_hs;
    bp_en = 1'b1;
    start_burst(6, 1'b1, 10);
    for (int b = 0; b < 10; b++) begin
      d = rand_msg();
      send(fwd(d, 6), 1'b1, d);
    end
    wait_done();
    bp_en = 1'b0;
    chk_int("bp_hs_count", 32'(dec_hs - h0), 32'd10);

    // Zero-length burst
    h0 = vnu_hs + dec_hs;
    start_burst(9, 1'b0, 0);
    @(negedge clk);
    chk_int("zl_busy", 32'(busy), 32'(1));
    chk_int("zl_done_c1", 32'(done), 32'(0));
    @(negedge clk);
    chk_int("zl_done_c2", 32'(done), 32'(1));
    chk_int("zl_no_beats", 32'(vnu_hs + dec_hs - h0), 32'(0));
    @(posedge clk);
    #1;

    // Shift 15 wraps to identity
    start_burst(15, 1'b1, 1);
    d = rand_msg();
    send(d, 1'b1, d);
    wait_done();

    // Reset mid-burst, then a clean 2-beat burst
    start_burst(4, 1'b0, 8);
    for (int b = 0; b < 4; b++) begin
      d = rand_msg();
      send(fwd(d, 4), 1'b0, d);
    end
    #1;
    rstn = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    h0 = vnu_hs;
    start_burst(4, 1'b0, 2);
    for (int b = 0; b < 2; b++) begin
      d = rand_msg();
      send(fwd(d, 4), 1'b0, d);
    end
    wait_done();
    chk_int("post_rst_hs", 32'(vnu_hs - h0), 32'd2);

    // start_i during RUN must not disturb the latched burst
    h0 = vnu_hs;
    h1 = dec_hs;
    start_burst(2, 1'b0, 4);
    d = rand_msg();
    send(fwd(d, 2), 1'b0, d);
    start   = 1'b1;
    shift   = 4'd5;
    dst_sel = 1'b1;
    blen    = 8'd9;
    d = rand_msg();
    send(fwd(d, 2), 1'b0, d);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d = rand_msg();
      send(fwd(d, 2), 1'b0, d);
    end
    wait_done();
    chk_int("busy_start_vnu", 32'(vnu_hs - h0), 32'd4);
    chk_int("busy_start_dec", 32'(dec_hs - h1), 32'd0);
    chk_int("busy_after_done", 32'(busy), 32'(0));

    chk_int("sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
